glitch_pulser: RTL and testbench

Single-shot glitch pulse generator that sits directly downstream of `clock_divider`. It consumes the divider's `out` square wave as a timebase tick. After being armed, it waits for a target trigger and counts a programmable number of timebase ticks. It then drives one glitch pulse of a programmable width, measured in `clk` cycles, to the glitch output stage.

---
 rtl/glitch_pulser.sv | 166 ++++++++++++++++
 tb/tb_glitch_pulser.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_pulser.sv
// ---------------------------------------------------------------------------
// glitch_pulser: armed single-shot glitch generator; delay in timebase ticks, width in clk cycles. Rev 1.0
// Define GLITCH_TRIG_SYNC_EN to pass the trigger through a 2-flop synchronizer.
// ---------------------------------------------------------------------------
`default_nettype none

module glitch_pulser #(
  parameter int BITS      = 16,
  parameter int SHOT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_in,
  input  logic                 trigger,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [BITS-1:0]      delay,
  input  logic [BITS-1:0]      width,
  output logic                 glitch,
  output logic                 busy,
  output logic                 done,
  output logic [SHOT_BITS-1:0] shots
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DELAY = 2'd2,
    S_PULSE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [BITS-1:0]      dly_q, dly_d;
  logic [BITS-1:0]      wid_q, wid_d;
  logic [BITS-1:0]      cnt_q, cnt_d;
  logic                 glitch_q, glitch_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [SHOT_BITS-1:0] shots_q, shots_d;
  logic                 tick_q, trig_q;
  logic                 trig_s;
  logic                 tick_rise, trig_rise;

`ifdef GLITCH_TRIG_SYNC_EN
  logic trig_m_q, trig_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_m_q <= 1'b0;
      trig_s_q <= 1'b0;
    end else begin
      trig_m_q <= trigger;
      trig_s_q <= trig_m_q;
    end
  end

  assign trig_s = trig_s_q;
`else
  assign trig_s = trigger;
`endif

  // History flops reset low so an input already high at reset release reads as a rising edge.
  assign tick_rise = tick_in & ~tick_q;
  assign trig_rise = trig_s & ~trig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dly_q    <= '0;
      wid_q    <= '0;
      cnt_q    <= '0;
      glitch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shots_q  <= '0;
      tick_q   <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      wid_q    <= wid_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      shots_q  <= shots_d;
      tick_q   <= tick_in;
      trig_q   <= trig_s;
    end
  end

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    wid_d    = wid_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    shots_d  = shots_q;

    if (abort) begin
      state_d  = S_IDLE;
      glitch_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            dly_d   = delay;
            wid_d   = (width == '0) ? BITS'(1) : width;
            state_d = S_ARMED;
            busy_d  = 1'b1;
          end
        end
        S_ARMED: begin
          if (trig_rise) begin
            if (dly_q == '0) begin
              state_d  = S_PULSE;
              glitch_d = 1'b1;
              cnt_d    = wid_q;
            end else begin
              state_d = S_DELAY;
              cnt_d   = dly_q;
            end
          end
        end
        S_DELAY: begin
          if (tick_rise) begin
            if (cnt_q == BITS'(1)) begin
              state_d  = S_PULSE;
              glitch_d = 1'b1;
              cnt_d    = wid_q;
            end else begin
              cnt_d = cnt_q - BITS'(1);
            end
          end
        end
        S_PULSE: begin
          // Counter loaded with the width on entry, so the pulse spans exactly wid_q cycles.
          if (cnt_q == BITS'(1)) begin
            state_d  = S_IDLE;
            glitch_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            shots_d  = shots_q + SHOT_BITS'(1);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q - BITS'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign glitch = glitch_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign shots  = shots_q;

endmodule

`default_nettype wire

// File: tb/tb_glitch_pulser.sv
// ---------------------------------------------------------------------------
// tb_glitch_pulser: directed self-checking bench for glitch_pulser with a width/shot scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_glitch_pulser;
  localparam int BITS      = 16;
  localparam int SHOT_BITS = 8;
`ifdef GLITCH_TRIG_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 tick_in;
  logic                 trigger;
  logic                 arm;
  logic                 abort;
  logic [BITS-1:0]      delay;
  logic [BITS-1:0]      width;
  logic                 glitch;
  logic                 busy;
  logic                 done;
  logic [SHOT_BITS-1:0] shots;

  typedef struct {
    int                   wid;
    logic [SHOT_BITS-1:0] shot;
  } exp_t;

  exp_t                 exp_q[$];
  logic [SHOT_BITS-1:0] shots_m;
  int                   n_vec;
  int                   n_miss;

  always #5 clk = ~clk;

  glitch_pulser #(.BITS(BITS), .SHOT_BITS(SHOT_BITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .trigger (trigger),
    .arm     (arm),
    .abort   (abort),
    .delay   (delay),
    .width   (width),
    .glitch  (glitch),
    .busy    (busy),
    .done    (done),
    .shots   (shots)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int d, input int w);
    exp_t e;
    arm   = 1'b1;
    delay = BITS'(d);
    width = BITS'(w);
    cyc();
    arm = 1'b0;
    chk("arm_busy", 32'(busy), 1);
    chk("arm_glitch", 32'(glitch), 0);
    chk("arm_done", 32'(done), 0);
    e.wid  = (w == 0) ? 1 : w;
    e.shot = shots_m + SHOT_BITS'(1);
    exp_q.push_back(e);
  endtask

  task automatic cancel_exp();
    if (exp_q.size() != 0) void'(exp_q.pop_back());
  endtask

  task automatic trig_to_pulse();
    trigger = 1'b1;
    repeat (LAT - 1) begin
      cyc();
      chk("lat_pre", 32'(glitch), 0);
    end
    cyc();
    chk("lat_glitch", 32'(glitch), 1);
    trigger = 1'b0;
  endtask

  task automatic trig_to_delay(input logic tick_same);
    trigger = 1'b1;
    repeat (LAT - 1) cyc();
    tick_in = tick_same;
    cyc();
    tick_in = 1'b0;
    trigger = 1'b0;
    chk("delay_busy", 32'(busy), 1);
    chk("delay_glitch", 32'(glitch), 0);
  endtask

  task automatic tick_once(input logic exp_g);
    tick_in = 1'b0;
    repeat (3) begin
      cyc();
      chk("tick_wait", 32'(glitch), 0);
    end
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
    chk("tick_edge", 32'(glitch), 32'(exp_g));
  endtask

  // Called with glitch already observed high; counts the pulse and scores it.
  task automatic measure();
    int   n;
    exp_t e;
    n = 1;
    cyc();
    while (glitch === 1'b1 && n < 100) begin
      n++;
      cyc();
    end
    chk("pulse_end", 32'(glitch), 0);
    chk("done_high", 32'(done), 1);
    chk("busy_low", 32'(busy), 0);
    chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("width", 32'(n), 32'(e.wid));
      chk("shots", 32'(shots), 32'(e.shot));
      shots_m = e.shot;
    end
  endtask

  task automatic run_shot(input int w);
    do_arm(0, w);
    trig_to_pulse();
    measure();
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    shots_m = '0;
    rst     = 1'b1;
    tick_in = 1'b0;
    trigger = 1'b0;
    arm     = 1'b0;
    abort   = 1'b0;
    delay   = '0;
    width   = '0;
    repeat (2) cyc();
    chk("rst_glitch", 32'(glitch), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_shots", 32'(shots), 0);
    rst = 1'b0;
    cyc();
    chk("idle_busy", 32'(busy), 0);

    // Minimum latency, then width-zero clamp armed with no dead cycle.
    run_shot(5);
    run_shot(0);

    // Delay of 3 ticks; a tick on the ARMED->DELAY edge must not count.
    do_arm(3, 2);
    trig_to_delay(1'b1);
    tick_once(1'b0);
    tick_once(1'b0);
    tick_once(1'b1);
    measure();

    // Arm while in DELAY is ignored.
    do_arm(4, 2);
    trig_to_delay(1'b0);
    tick_once(1'b0);
    arm   = 1'b1;
    delay = BITS'(7);
    width = BITS'(9);
    cyc();
    arm = 1'b0;
    chk("rearm_busy", 32'(busy), 1);
    chk("rearm_glitch", 32'(glitch), 0);
    tick_once(1'b0);
    tick_once(1'b0);
    tick_once(1'b1);
    measure();

    // Abort mid-DELAY, coincident with a tick rise.
    do_arm(10, 3);
    trig_to_delay(1'b0);
    tick_once(1'b0);
    tick_once(1'b0);
    abort   = 1'b1;
    tick_in = 1'b1;
    cyc();
    abort   = 1'b0;
    tick_in = 1'b0;
    cancel_exp();
    chk("abd_busy", 32'(busy), 0);
    chk("abd_glitch", 32'(glitch), 0);
    chk("abd_done", 32'(done), 0);
    chk("abd_shots", 32'(shots), 32'(shots_m));
    repeat (10) tick_once(1'b0);
    chk("abd_done_late", 32'(done), 0);

    // Abort during PULSE.
    do_arm(0, 8);
    trig_to_pulse();
    cyc();
    cyc();
    chk("abp_still_high", 32'(glitch), 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cancel_exp();
    chk("abp_glitch", 32'(glitch), 0);
    chk("abp_busy", 32'(busy), 0);
    chk("abp_done", 32'(done), 0);
    cyc();
    chk("abp_done_late", 32'(done), 0);
    chk("abp_shots", 32'(shots), 32'(shots_m));

    // Simultaneous arm and abort in IDLE stays IDLE.
    arm   = 1'b1;
    abort = 1'b1;
    delay = '0;
    width = BITS'(4);
    cyc();
    arm   = 1'b0;
    abort = 1'b0;
    chk("armab_busy", 32'(busy), 0);
    trigger = 1'b1;
    repeat (LAT + 2) cyc();
    chk("armab_glitch", 32'(glitch), 0);
    chk("armab_busy2", 32'(busy), 0);
    trigger = 1'b0;
    repeat (3) cyc();

    // Reset while glitch is high.
    do_arm(0, 6);
    trig_to_pulse();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cancel_exp();
    shots_m = '0;
    chk("rstp_glitch", 32'(glitch), 0);
    chk("rstp_busy", 32'(busy), 0);
    chk("rstp_done", 32'(done), 0);
    chk("rstp_shots", 32'(shots), 0);
    cyc();

    // 256 completed shots wrap the 8-bit counter back to zero.
    for (int i = 0; i < 256; i++) run_shot(0);
    chk("shots_wrap", 32'(shots), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
